// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings common with uart_tx, the default
// oversampling factor, the system clock rate and the baud divisor helper.
package uart_rx_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned DEF_FRE_MUL   = 16;
    localparam int unsigned DEF_BAUD_RATE = 115_200;

    // Encodings are fixed because uart_tx decodes the same values.
    typedef enum logic [3:0] {
        ST_NULL  = 4'd0,
        ST_IDLE  = 4'd1,
        ST_START = 4'd2,
        ST_BIT0  = 4'd3,
        ST_BIT1  = 4'd4,
        ST_BIT2  = 4'd5,
        ST_BIT3  = 4'd6,
        ST_BIT4  = 4'd7,
        ST_BIT5  = 4'd8,
        ST_BIT6  = 4'd9,
        ST_BIT7  = 4'd10,
        ST_PAR   = 4'd11,
        ST_STOP  = 4'd12
    } uart_state_t;

    // sys_clk cycles between two oversampling ticks.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned fre_mul);
        return clk_hz / (baud * fre_mul);
    endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// uart_baud: free-running oversampling tick generator. Emits a one-cycle
// bps_clk_up pulse fre_mul times per bit period.
import uart_rx_pkg::*;

module uart_baud #(
    parameter int unsigned fre_mul   = DEF_FRE_MUL,
    parameter int unsigned baud_rate = DEF_BAUD_RATE
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic bps_clk_up
);

    localparam int unsigned DIV     = baud_div(CLK_HZ, baud_rate, fre_mul);
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_tick;

    // Divide sys_clk down and pulse once per wrap of the divider.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == LAST) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_tick    <= 1'b0;
        end
    end

    assign bps_clk_up = r_tick;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
import uart_rx_pkg::*;

module uart_rx #(
    parameter int unsigned FRE_MUL   = DEF_FRE_MUL,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data_o,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_idle
);

    // Tick counts at which the start bit and every later bit are judged.
    localparam logic [3:0] TICK_MID  = 4'(FRE_MUL / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(FRE_MUL - 1);

    logic        r_rx_st1;
    logic        r_rx_st2;
    logic        w_bps_tick;
    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [3:0]  r_tick_cnt;
    logic [7:0]  r_shift;
    logic        r_rx_done;
    logic        r_rx_frame_err;
    logic        r_rx_idle;
    logic        w_tick_clr;
    logic        w_shift_en;
    logic        w_done;
    logic        w_frame_err;
`ifdef UART_RX_PARITY_EN
    logic        w_par_sample;
    logic        w_parity_err;
    logic        r_par_bad;
    logic        r_rx_parity_err;
`endif

    uart_baud #(
        .fre_mul   (FRE_MUL),
        .baud_rate (BAUD_RATE)
    ) baud_rx (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .bps_clk_up (w_bps_tick)
    );

    // Two-flop synchronizer for the asynchronous line; idles high.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_st1 <= 1'b1;
            r_rx_st2 <= 1'b1;
        end else begin
            r_rx_st1 <= rxd;
            r_rx_st2 <= r_rx_st1;
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_NULL;
        else        r_state <= w_state_next;
    end

    // Next-state and per-tick actions; every decision happens on a baud tick.
    // NOTE: each output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_tick_clr   = 1'b0;
        w_shift_en   = 1'b0;
        w_done       = 1'b0;
        w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
        w_parity_err = 1'b0;
`endif
        case (r_state)
            ST_NULL: begin
                if (w_bps_tick) begin
                    w_state_next = ST_IDLE;
                    w_tick_clr   = 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_bps_tick && !r_rx_st2) begin
                    w_state_next = ST_START;
                    w_tick_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (w_bps_tick && r_tick_cnt == TICK_MID) begin
                    w_tick_clr   = 1'b1;
                    // Line high again at mid start bit: it was only a glitch.
                    w_state_next = r_rx_st2 ? ST_IDLE : ST_BIT0;
                end
            end
            ST_BIT0, ST_BIT1, ST_BIT2, ST_BIT3,
            ST_BIT4, ST_BIT5, ST_BIT6: begin
                if (w_bps_tick && r_tick_cnt == TICK_LAST) begin
                    w_shift_en   = 1'b1;
                    w_tick_clr   = 1'b1;
                    w_state_next = uart_state_t'(r_state + 4'd1);
                end
            end
            ST_BIT7: begin
                if (w_bps_tick && r_tick_cnt == TICK_LAST) begin
                    w_shift_en   = 1'b1;
                    w_tick_clr   = 1'b1;
`ifdef UART_RX_PARITY_EN
                    w_state_next = ST_PAR;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PAR: begin
                if (w_bps_tick && r_tick_cnt == TICK_LAST) begin
                    w_par_sample = 1'b1;
                    w_tick_clr   = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid stop bit keeps half a bit to catch the next start.
                if (w_bps_tick && r_tick_cnt == TICK_LAST) begin
                    w_tick_clr   = 1'b1;
                    w_state_next = ST_IDLE;
                    if (!r_rx_st2) begin
                        w_frame_err = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) w_parity_err = 1'b1;
                        else           w_done       = 1'b1;
`else
                        w_done = 1'b1;
`endif
                    end
                end
            end
            default: begin
                w_state_next = ST_NULL;
                w_tick_clr   = 1'b1;
            end
        endcase
    end

    // Tick counter, data shifter and registered output strobes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt     <= 4'd0;
            r_shift        <= 8'h00;
            rx_data_o      <= 8'h00;
            r_rx_done      <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_idle      <= 1'b0;
        end else begin
            if (w_tick_clr)      r_tick_cnt <= 4'd0;
            else if (w_bps_tick) r_tick_cnt <= r_tick_cnt + 4'd1;

            // LSB arrives first, so shift right and insert at the top.
            if (w_shift_en) r_shift <= {r_rx_st2, r_shift[7:1]};
            if (w_done)     rx_data_o <= r_shift;

            r_rx_done      <= w_done;
            r_rx_frame_err <= w_frame_err;
            r_rx_idle      <= (w_state_next == ST_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad       <= 1'b0;
            r_rx_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) r_par_bad <= (^r_shift) ^ r_rx_st2;
            r_rx_parity_err <= w_parity_err;
        end
    end

    assign rx_parity_err = r_rx_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_done      = r_rx_done;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_idle      = r_rx_idle;

endmodule

// File: doc/uart_rx.md
# uart_rx

8-bit, no-parity (by default) UART receiver, the receiving end paired with `uart_tx` in the UART/RAM datapath. It oversamples the serial `rxd` line at 16x the bit rate using a `uart_baud` instance, finds the start bit, samples each data bit at mid-bit, and presents the received byte with a one-cycle completion strobe. Its output feeds the RAM write path, and it flags broken frames.

## Interface
Parameters:
- `FRE_MUL`, default 16, is the oversampling factor passed to `uart_baud`. Only 16 is supported; the mid-bit point is `FRE_MUL/2`.

Ports:
- `sys_clk` input, 1 bit: 100 MHz system clock. This is the only clock.
- `rst_n` input, 1 bit: global reset. Asynchronous, active-low.
- `rxd` input, 1 bit: UART RXD line. It is asynchronous to `sys_clk` and idles high.
- `rx_data_o` output, 8 bits: last correctly received byte, LSB first on the wire. It holds its value until the next good frame.
- `rx_done` output, 1 bit: one-`sys_clk` pulse when `rx_data_o` has been updated.
- `rx_frame_err` output, 1 bit: one-`sys_clk` pulse when the stop bit is sampled low.
- `rx_parity_err` output, 1 bit: one-`sys_clk` pulse on a parity mismatch. It is tied to 0 unless `UART_RX_PARITY_EN` is defined.
- `rx_idle` output, 1 bit: high while the receiver is in IDLE.

## Operation
- **Input synchronizer:** `rxd` passes through a two-flop synchronizer, `rx_st1`/`rx_st2`, both reset to 1. All logic uses `rx_st2` only.
- **Tick source:** `uart_baud #(.fre_mul(FRE_MUL))` produces `bps_clk_up`. This is a one-`sys_clk` pulse, 16 per bit period.
- **Tick counter:** `tick_cnt` is 4 bits and advances only on `bps_clk_up`. It is cleared on every state entry and wraps from 15 to 0.
- **States:** NULL, IDLE, START, BIT0 to BIT7, PAR (only with the macro), STOP.
  - NULL: reset state. Goes to IDLE on the first `bps_clk_up`.
  - IDLE: moves to START on a `bps_clk_up` where `rx_st2` is 0, and clears `tick_cnt`.
  - START: on the tick where `tick_cnt` reaches 7 (mid start bit):
    - if `rx_st2` is 1, it was a false start; return to IDLE with no outputs;
    - otherwise go to BIT0 and clear `tick_cnt`.
  - BIT0 to BIT7: on the tick where `tick_cnt` reaches 15 (one bit period later, mid-bit), shift `rx_st2` into `shift_r[7]` (right shift), then move to the next bit state. BIT7 goes to STOP, or to PAR with the macro.
  - STOP: on the tick where `tick_cnt` reaches 15, sample `rx_st2` and go to IDLE.
    - Sample is 1: load `rx_data_o` from `shift_r` and pulse `rx_done`.
    - Sample is 0: pulse `rx_frame_err`; `rx_data_o` is unchanged.
  - STOP returns to IDLE at mid stop bit. This leaves half a bit of margin, so the next start edge is caught when frames arrive back-to-back from `uart_tx`.
  - Illegal state encodings go to NULL.
- **Reset values:**
  - `state` = NULL
  - `rx_data_o` = 8'h00
  - `shift_r` = 8'h00
  - `tick_cnt` = 0
  - `rx_done` = 0, `rx_frame_err` = 0, `rx_parity_err` = 0
  - `rx_idle` = 0 (it goes to 1 on entry to IDLE)
- **Reset mid-frame:** reset drops the partial byte immediately, and no strobe is issued. After reset, a frame already in progress is recovered only from a later start edge. A data bit seen as a falling edge may be misread as a start bit; that frame will then fail with `rx_frame_err`, and this behaviour is accepted.

## Timing
- Bit period is 16 `bps_clk_up` ticks. Start is detected within 1 tick of the synchronized falling edge.
- Each bit is sampled 8 to 9 ticks after its leading edge.
- `rx_done` and `rx_frame_err` are registered. They assert in the `sys_clk` cycle after the STOP sampling tick and last exactly one `sys_clk` cycle.
- End-to-end latency from the `rxd` start edge to `rx_done` is about 9.5 bit periods plus 3 `sys_clk` cycles (2 synchronizer, 1 output register).
- `rx_done` and `rx_frame_err` are never high in the same cycle.
- `rx_idle` falls in the cycle after the IDLE to START transition.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a PAR state is inserted between BIT7 and STOP, sampled at `tick_cnt` 15. Even parity is used: the XOR of the 8 data bits and the parity bit must be 0.
    - On a mismatch, `rx_parity_err` pulses in the same cycle that `rx_done` would have pulsed, and `rx_data_o` is not updated.
    - A stop error takes precedence: `rx_frame_err` pulses only and `rx_parity_err` stays 0.
  - Not defined: there is no PAR state, the frame is 10 bits, and `rx_parity_err` is held at 0.

## Structure
- State encodings (NULL=0, IDLE=1, START=2, BIT0 to BIT7 = 3 to 10, PAR=11, STOP=12) are shared with `uart_tx`. They belong in `uart_defines.v`, with the default `FRE_MUL` and the baud divisor constants.
- There is one sub-module, the existing `uart_baud`, instantiated as `baud_rx`. No other hierarchy is used.

## Test plan
- Frame 0xA5 at the nominal baud rate, macro off: `rx_data_o`=8'hA5, one `rx_done` pulse, `rx_frame_err`=0, `rx_idle` back to 1.
- Low glitch on `rxd` lasting 4 ticks while idle: no strobe, state returns to IDLE, `rx_data_o` is unchanged.
- Frame 0x3C sent with the stop bit forced to 0: `rx_frame_err` pulses once, `rx_done`=0, `rx_data_o` keeps its previous value.
- `uart_tx` looped back sending 0x00 then 0xFF back-to-back: two `rx_done` pulses, with data 8'h00 then 8'hFF.
- `rst_n` asserted during BIT3 of frame 0x55, then a fresh 0x81 sent: no strobe for 0x55, `rx_data_o` reads 8'h00 until 0x81 is received correctly.
- With `UART_RX_PARITY_EN`:
  - 0x0F with parity 0: `rx_done` pulses.
  - 0x0F with parity 1: `rx_parity_err` pulses, `rx_done`=0.
